// File: rtl/bcd_time_counter.sv
// BCD stopwatch/countdown core: MM:SS or HH:MM:SS with preset load, lap freeze,
// sticky expiry flag and a wrap pulse. All state advances on the 1 Hz edge.
module bcd_time_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk_1Hz,
  input  logic                reset,
  input  logic                run,
  input  logic                dir,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] disp,
  output logic                expired,
  output logic                ovf
);

  localparam int W = 4 * DIGITS;

  if (DIGITS != 4 && DIGITS != 6) begin : g_bad_digits
    $error("bcd_time_counter: DIGITS must be 4 or 6");
  end

  // Tens-of-seconds and tens-of-minutes roll at 5; every other digit at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 1 || idx == 3) ? 4'd5 : 4'd9;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] cap_q, cap_d;
  logic         lap_q, lap_d;
  logic         expired_q, expired_d;
  logic         ovf_q, ovf_d;
  logic         carry;
  logic         at_max;
  logic         at_zero;
  logic [3:0]   nib;

  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    ovf_d     = 1'b0;
    carry     = 1'b1;
    at_max    = 1'b1;
    at_zero   = 1'b1;
    nib       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      at_max  = at_max & (count_q[4*i +: 4] == digit_max(i));
      at_zero = at_zero & (count_q[4*i +: 4] == 4'd0);
    end

    if (clear) begin
      count_d   = '0;
      expired_d = 1'b0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_val[4*i +: 4];
        count_d[4*i +: 4] = (nib > digit_max(i)) ? digit_max(i) : nib;
      end
      expired_d = 1'b0;
    end else if (run) begin
      if (!dir) begin
        if (at_max) begin
          if (WRAP) begin
            count_d = '0;
            ovf_d   = 1'b1;
          end
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
              if (count_q[4*i +: 4] == digit_max(i)) begin
                count_d[4*i +: 4] = 4'd0;
              end else begin
                count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end else if (!at_zero) begin
        // Borrow ripple; zero is a floor, never an underflow.
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (count_q[4*i +: 4] == 4'd0) begin
              count_d[4*i +: 4] = digit_max(i);
            end else begin
              count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
        expired_d = expired_q | (count_d == '0);
      end
    end
  end

  always_comb begin
    lap_d = lap;
    cap_d = (lap && !lap_q) ? count_q : cap_q;
  end

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      cap_q     <= '0;
      lap_q     <= 1'b0;
      expired_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      cap_q     <= cap_d;
      lap_q     <= lap_d;
      expired_q <= expired_d;
      ovf_q     <= ovf_d;
    end
  end

  assign disp    = lap_q ? cap_q : count_q;
  assign expired = expired_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: MM:SS wrap and saturate builds plus an
// HH:MM:SS build, all sharing the same control inputs.
module tb_bcd_time_counter;

  logic        clk_1Hz = 1'b0;
  logic        reset   = 1'b0;
  logic        run     = 1'b0;
  logic        dir     = 1'b0;
  logic        clear   = 1'b0;
  logic        load    = 1'b0;
  logic        lap     = 1'b0;
  logic [15:0] load_val4 = '0;
  logic [23:0] load_val6 = '0;

  logic [15:0] disp_w, disp_s;
  logic [23:0] disp_6;
  logic        exp_w, exp_s, exp_6;
  logic        ovf_w, ovf_s, ovf_6;

  int errors = 0;
  int checks = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  bcd_time_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val4), .lap(lap),
    .disp(disp_w), .expired(exp_w), .ovf(ovf_w));

  bcd_time_counter #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val4), .lap(lap),
    .disp(disp_s), .expired(exp_s), .ovf(ovf_s));

  bcd_time_counter #(.DIGITS(6), .WRAP(1'b1)) u_hms (
    .clk_1Hz(clk_1Hz), .reset(reset), .run(run), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val6), .lap(lap),
    .disp(disp_6), .expired(exp_6), .ovf(ovf_6));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_1Hz);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (disp_w !== 16'h0000 || exp_w !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_4: disp=%h exp=%b ovf=%b want 0000/0/0", disp_w, exp_w, ovf_w);
    end
    checks++;
    if (disp_6 !== 24'h000000 || exp_6 !== 1'b0 || ovf_6 !== 1'b0) begin
      errors++;
      $display("FAIL reset_6: disp=%h exp=%b ovf=%b want 000000/0/0", disp_6, exp_6, ovf_6);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_up_count();
    run = 1'b1; dir = 1'b0;
    tick(75);
    checks++;
    if (disp_w !== 16'h0115 || exp_w !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL up75_4: disp=%h exp=%b ovf=%b want 0115/0/0", disp_w, exp_w, ovf_w);
    end
    checks++;
    if (disp_6 !== 24'h000115) begin
      errors++;
      $display("FAIL up75_6: disp=%h want 000115", disp_6);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (disp_w !== 16'h0000 || disp_6 !== 24'h000000) begin
      errors++;
      $display("FAIL async_reset: disp4=%h disp6=%h want 0", disp_w, disp_6);
    end
    run = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_wrap_saturate();
    run = 1'b0; dir = 1'b0; load = 1'b1; load_val4 = 16'h5958;
    tick(1);
    load = 1'b0; run = 1'b1;
    tick(1);
    checks++;
    if (disp_w !== 16'h5959 || ovf_w !== 1'b0 || disp_s !== 16'h5959 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL wrap_e1: w=%h/%b s=%h/%b want 5959/0 both", disp_w, ovf_w, disp_s, ovf_s);
    end
    tick(1);
    checks++;
    if (disp_w !== 16'h0000 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_e2: disp=%h ovf=%b want 0000/1", disp_w, ovf_w);
    end
    checks++;
    if (disp_s !== 16'h5959 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_e2: disp=%h ovf=%b want 5959/0", disp_s, ovf_s);
    end
    tick(1);
    checks++;
    if (disp_w !== 16'h0001 || ovf_w !== 1'b0 || disp_s !== 16'h5959 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL wrap_e3: w=%h/%b s=%h/%b want 0001/0 5959/0", disp_w, ovf_w, disp_s, ovf_s);
    end
    run = 1'b0;
  endtask

  task automatic test_countdown();
    run = 1'b0; load = 1'b1; load_val4 = 16'h0102; load_val6 = 24'h000102;
    tick(1);
    load = 1'b0; run = 1'b1; dir = 1'b1;
    tick(61);
    checks++;
    if (disp_w !== 16'h0001 || exp_w !== 1'b0) begin
      errors++;
      $display("FAIL down61: disp=%h exp=%b want 0001/0", disp_w, exp_w);
    end
    tick(1);
    checks++;
    if (disp_w !== 16'h0000 || exp_w !== 1'b1 || disp_6 !== 24'h000000 || exp_6 !== 1'b1) begin
      errors++;
      $display("FAIL down62: d4=%h e4=%b d6=%h e6=%b want 0/1", disp_w, exp_w, disp_6, exp_6);
    end
    tick(3);
    checks++;
    if (disp_w !== 16'h0000 || exp_w !== 1'b1) begin
      errors++;
      $display("FAIL down_floor: disp=%h exp=%b want 0000/1", disp_w, exp_w);
    end
    dir = 1'b0;
    tick(1);
    checks++;
    if (disp_w !== 16'h0001 || exp_w !== 1'b1) begin
      errors++;
      $display("FAIL up_after_expire: disp=%h exp=%b want 0001/1", disp_w, exp_w);
    end
    run = 1'b0; load = 1'b1; load_val4 = 16'h0010;
    tick(1);
    load = 1'b0;
    checks++;
    if (disp_w !== 16'h0010 || exp_w !== 1'b0) begin
      errors++;
      $display("FAIL load_clears_exp: disp=%h exp=%b want 0010/0", disp_w, exp_w);
    end
  endtask

  task automatic test_clamp_priority();
    run = 1'b1; dir = 1'b0;
    load = 1'b1; clear = 1'b1; load_val4 = 16'h9F9F; load_val6 = 24'hAA9F9F;
    tick(1);
    checks++;
    if (disp_w !== 16'h0000 || disp_6 !== 24'h000000) begin
      errors++;
      $display("FAIL clear_over_load: d4=%h d6=%h want 0", disp_w, disp_6);
    end
    clear = 1'b0; run = 1'b0;
    tick(1);
    load = 1'b0;
    checks++;
    if (disp_w !== 16'h5959) begin
      errors++;
      $display("FAIL clamp_4: disp=%h want 5959", disp_w);
    end
    checks++;
    if (disp_6 !== 24'h995959) begin
      errors++;
      $display("FAIL clamp_6: disp=%h want 995959", disp_6);
    end
  endtask

  task automatic test_lap();
    int bad = 0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0; run = 1'b1; dir = 1'b0;
    tick(10);
    checks++;
    if (disp_w !== 16'h0010) begin
      errors++;
      $display("FAIL lap_pre: disp=%h want 0010", disp_w);
    end
    lap = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (disp_w !== 16'h0010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lap_hold: %0d of 20 edges off, last disp=%h want 0010", bad, disp_w);
    end
    lap = 1'b0;
    tick(1);
    checks++;
    if (disp_w !== 16'h0031) begin
      errors++;
      $display("FAIL lap_release: disp=%h want 0031", disp_w);
    end
    run = 1'b0;
  endtask

  task automatic test_borrow6();
    load = 1'b1; load_val6 = 24'h010000;
    tick(1);
    load = 1'b0; run = 1'b1; dir = 1'b1;
    tick(1);
    checks++;
    if (disp_6 !== 24'h005959 || exp_6 !== 1'b0) begin
      errors++;
      $display("FAIL borrow6: disp=%h exp=%b want 005959/0", disp_6, exp_6);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap_saturate();
    test_countdown();
    test_clamp_priority();
    test_lap();
    test_borrow6();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
